// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM encoding,
// port identifiers and default geometry.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF     = 20;
    localparam int MEM_HWORDS_DEF = 1024;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Winner selection between the pipeline port (0) and the stack/interrupt
// port (1), either round-robin on last grant or fixed with port 0 first.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    input  logic rr_en,
    output logic winner
);

    // Contention goes to the port not granted last; otherwise port 0 wins.
    always_comb begin
        winner = PORT0;
        if (req0 && req1) begin
            winner = (rr_en && (last_grant == PORT0)) ? PORT1 : PORT0;
        end else if (req1) begin
            winner = PORT1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single 16-bit-location data memory; each
// access takes IDLE -> ACCESS -> RESP and completes with a one-cycle ack.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int MEM_HWORDS = MEM_HWORDS_DEF,
    parameter int RR_EN      = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_we0,
    input  logic              i_we1,
    input  logic              i_en32_0,
    input  logic              i_en32_1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [31:0]       i_wdata0,
    input  logic [31:0]       i_wdata1,

    output logic              o_ack0,
    output logic              o_ack1,
    output logic              o_err0,
    output logic              o_err1,
    output logic [31:0]       o_rdata0,
    output logic [31:0]       o_rdata1,

    output logic              o_mem_read,
    output logic              o_mem_write,
    output logic              o_mem_en32,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata
);

    // One extra bit so the limit itself is representable for any ADDR_W.
    localparam logic [ADDR_W:0] HW_LIMIT = (ADDR_W+1)'(MEM_HWORDS);

    state_t            state;
    logic              last_grant;
    logic              winner;

    logic              sel_we;
    logic              sel_en32;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic              sel_oor;

    logic              lat_port;
    logic              lat_we;
    logic              lat_en32;
    logic              lat_oor;
    logic [31:0]       resp_rdata;

    dmem_arb_pick u_pick (
        .req0       (i_req0),
        .req1       (i_req1),
        .last_grant (last_grant),
        .rr_en      (RR_EN != 0),
        .winner     (winner)
    );

    always_comb begin
        sel_we    = (winner == PORT1) ? i_we1    : i_we0;
        sel_en32  = (winner == PORT1) ? i_en32_1 : i_en32_0;
        sel_addr  = (winner == PORT1) ? i_addr1  : i_addr0;
        sel_wdata = (winner == PORT1) ? i_wdata1 : i_wdata0;
        sel_oor   = ({1'b0, sel_addr} >= HW_LIMIT) ||
                    (sel_en32 && ({1'b0, sel_addr} == (HW_LIMIT - 1'b1)));
    end

    // Out-of-range accesses still walk through ACCESS but never strobe the memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= PORT1;
            lat_port    <= PORT0;
            lat_we      <= 1'b0;
            lat_en32    <= 1'b0;
            lat_oor     <= 1'b0;
            o_mem_read  <= 1'b0;
            o_mem_write <= 1'b0;
            o_mem_en32  <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_ack0      <= 1'b0;
            o_ack1      <= 1'b0;
            o_err0      <= 1'b0;
            o_err1      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req0 || i_req1) begin
                        state       <= ACCESS;
                        last_grant  <= winner;
                        lat_port    <= winner;
                        lat_we      <= sel_we;
                        lat_en32    <= sel_en32;
                        lat_oor     <= sel_oor;
                        o_mem_read  <= !sel_we && !sel_oor;
                        o_mem_write <= sel_we && !sel_oor;
                        o_mem_en32  <= sel_en32;
                        o_mem_addr  <= sel_addr;
                        o_mem_wdata <= sel_en32 ? sel_wdata : {16'h0000, sel_wdata[15:0]};
                    end
                end
                ACCESS: begin
                    state       <= RESP;
                    o_mem_read  <= 1'b0;
                    o_mem_write <= 1'b0;
                    o_mem_en32  <= 1'b0;
                    o_mem_addr  <= '0;
                    o_mem_wdata <= '0;
                    o_ack0      <= (lat_port == PORT0);
                    o_ack1      <= (lat_port == PORT1);
                    o_err0      <= (lat_port == PORT0) && lat_oor;
                    o_err1      <= (lat_port == PORT1) && lat_oor;
                end
                RESP: begin
                    state  <= IDLE;
                    o_ack0 <= 1'b0;
                    o_ack1 <= 1'b0;
                    o_err0 <= 1'b0;
                    o_err1 <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory data only arrives on the edge that enters RESP, so it is forwarded combinationally.
    always_comb begin
        resp_rdata = '0;
        if ((state == RESP) && !lat_we && !lat_oor) begin
            resp_rdata = lat_en32 ? i_mem_rdata : {16'h0000, i_mem_rdata[15:0]};
        end
    end

    assign o_rdata0 = (lat_port == PORT0) ? resp_rdata : '0;
    assign o_rdata1 = (lat_port == PORT1) ? resp_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a round-robin instance on a behavioural
// memory plus a fixed-priority instance sharing the request fields.
module tb_dmem_arbiter;

    typedef struct packed {
        logic        port;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req0, req1, f_req0, f_req1;
    logic        we0, we1, en0, en1;
    logic [19:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;

    logic        o_ack0, o_ack1, o_err0, o_err1;
    logic [31:0] o_rdata0, o_rdata1;
    logic        o_mem_read, o_mem_write, o_mem_en32;
    logic [19:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [31:0] mem_rdata;

    logic        f_ack0, f_ack1, f_err0, f_err1;
    logic [31:0] f_rdata0, f_rdata1;
    logic        f_mem_read, f_mem_write, f_mem_en32;
    logic [19:0] f_mem_addr;
    logic [31:0] f_mem_wdata;

    logic [15:0] mem [0:1023] = '{default: 16'h0000};

    exp_t        q_main[$];
    exp_t        q_fp[$];
    exp_t        e_main, e_fp;
    logic        oor_watch;
    int          checks;
    int          failures;

    dmem_arbiter #(.ADDR_W(20), .MEM_HWORDS(1024), .RR_EN(1)) dut (
        .clk(clk), .rst(rst),
        .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
        .i_en32_0(en0), .i_en32_1(en1), .i_addr0(addr0), .i_addr1(addr1),
        .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_ack0(o_ack0), .o_ack1(o_ack1), .o_err0(o_err0), .o_err1(o_err1),
        .o_rdata0(o_rdata0), .o_rdata1(o_rdata1),
        .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_mem_en32(o_mem_en32),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.ADDR_W(20), .MEM_HWORDS(1024), .RR_EN(0)) dut_fp (
        .clk(clk), .rst(rst),
        .i_req0(f_req0), .i_req1(f_req1), .i_we0(we0), .i_we1(we1),
        .i_en32_0(en0), .i_en32_1(en1), .i_addr0(addr0), .i_addr1(addr1),
        .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_ack0(f_ack0), .o_ack1(f_ack1), .o_err0(f_err0), .o_err1(f_err1),
        .o_rdata0(f_rdata0), .o_rdata1(f_rdata1),
        .o_mem_read(f_mem_read), .o_mem_write(f_mem_write), .o_mem_en32(f_mem_en32),
        .o_mem_addr(f_mem_addr), .o_mem_wdata(f_mem_wdata), .i_mem_rdata(32'h0000_0000)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: read data is registered on the edge ending the read cycle.
    always @(posedge clk) begin
        if (o_mem_write) begin
            mem[o_mem_addr[9:0]] <= o_mem_wdata[15:0];
            if (o_mem_en32) mem[o_mem_addr[9:0] + 10'd1] <= o_mem_wdata[31:16];
        end
        if (o_mem_read) mem_rdata <= {mem[o_mem_addr[9:0] + 10'd1], mem[o_mem_addr[9:0]]};
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_acks"}, {28'h0, o_ack0, o_ack1, f_ack0, f_ack1}, 32'h0);
        checkOutput({tag, "_errs"}, {30'h0, o_err0, o_err1}, 32'h0);
        checkOutput({tag, "_rdata0"}, o_rdata0, 32'h0);
        checkOutput({tag, "_rdata1"}, o_rdata1, 32'h0);
        checkOutput({tag, "_mem_ctrl"}, {29'h0, o_mem_read, o_mem_write, o_mem_en32}, 32'h0);
        checkOutput({tag, "_mem_addr"}, 32'(o_mem_addr), 32'h0);
        checkOutput({tag, "_mem_wdata"}, o_mem_wdata, 32'h0);
    endtask

    task automatic setPort(input int port, input logic we, input logic en32,
                           input logic [19:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            we0 = we; en0 = en32; addr0 = addr; wdata0 = wdata;
        end else begin
            we1 = we; en1 = en32; addr1 = addr; wdata1 = wdata;
        end
    endtask

    // Single uncontended access on the round-robin instance; also checks the 2-cycle latency.
    task automatic applyStimulus(input int port, input logic we, input logic en32,
                                 input logic [19:0] addr, input logic [31:0] wdata,
                                 input logic exp_err, input logic [31:0] exp_rdata);
        int   cnt;
        logic acked;
        q_main.push_back('{port: port[0], err: exp_err, rdata: exp_rdata});
        setPort(port, we, en32, addr, wdata);
        if (port == 0) req0 = 1'b1; else req1 = 1'b1;
        cnt   = 0;
        acked = 1'b0;
        while (!acked && cnt < 10) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            acked = (port == 0) ? o_ack0 : o_ack1;
        end
        checkOutput($sformatf("latency_p%0d_addr%h", port, addr), 32'(cnt), 32'd2);
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
    endtask

    // Hold both requests until each port has collected its quota of acks.
    task automatic run_pair(input int inst, input int n0, input int n1);
        int   r0, r1, guard;
        logic a0, a1;
        r0 = n0; r1 = n1; guard = 0;
        if (inst == 0) begin req0 = (n0 > 0); req1 = (n1 > 0); end
        else begin f_req0 = (n0 > 0); f_req1 = (n1 > 0); end
        while ((r0 > 0 || r1 > 0) && guard < 60) begin
            @(negedge clk);
            guard++;
            a0 = (inst == 0) ? o_ack0 : f_ack0;
            a1 = (inst == 0) ? o_ack1 : f_ack1;
            if (a0 && r0 > 0) begin
                r0--;
                if (r0 == 0) begin if (inst == 0) req0 = 1'b0; else f_req0 = 1'b0; end
            end
            if (a1 && r1 > 0) begin
                r1--;
                if (r1 == 0) begin if (inst == 0) req1 = 1'b0; else f_req1 = 1'b0; end
            end
        end
        if (guard >= 60) begin
            checks++;
            failures++;
            $display("[TB] FAIL run_pair_timeout inst=%0d remaining=%0d/%0d expected=0/0", inst, r0, r1);
        end
        req0 = 1'b0; req1 = 1'b0; f_req0 = 1'b0; f_req1 = 1'b0;
        @(negedge clk);
    endtask

    // Scoreboard monitor for the round-robin instance.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_ack0 || o_ack1) begin
                checkOutput("dual_ack", 32'(o_ack0 & o_ack1), 32'h0);
                if (q_main.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_ack actual=ack0:%0b,ack1:%0b expected=no_ack", o_ack0, o_ack1);
                end else begin
                    e_main = q_main.pop_front();
                    checkOutput("grant_port", 32'(o_ack1), 32'(e_main.port));
                    checkOutput("resp_err", 32'(o_ack1 ? o_err1 : o_err0), 32'(e_main.err));
                    checkOutput("resp_rdata", o_ack1 ? o_rdata1 : o_rdata0, e_main.rdata);
                end
            end
            if (!o_ack0) checkOutput("p0_quiet", o_rdata0 | 32'(o_err0), 32'h0);
            if (!o_ack1) checkOutput("p1_quiet", o_rdata1 | 32'(o_err1), 32'h0);
            if (oor_watch) checkOutput("oor_mem_ctrl", {30'h0, o_mem_read, o_mem_write}, 32'h0);
        end
    end

    // Scoreboard monitor for the fixed-priority instance.
    always @(negedge clk) begin
        if (!rst && (f_ack0 || f_ack1)) begin
            if (q_fp.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL fp_unexpected_ack actual=ack0:%0b,ack1:%0b expected=no_ack", f_ack0, f_ack1);
            end else begin
                e_fp = q_fp.pop_front();
                checkOutput("fp_grant_port", 32'(f_ack1), 32'(e_fp.port));
                checkOutput("fp_resp_err", 32'(f_ack1 ? f_err1 : f_err0), 32'(e_fp.err));
                checkOutput("fp_resp_rdata", f_ack1 ? f_rdata1 : f_rdata0, e_fp.rdata);
            end
        end
    end

    initial begin
        checks = 0; failures = 0; oor_watch = 1'b0;
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0; f_req0 = 1'b0; f_req1 = 1'b0;
        setPort(0, 1'b0, 1'b0, 20'h0, 32'h0);
        setPort(1, 1'b0, 1'b0, 20'h0, 32'h0);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        checkIdleOutputs("reset");
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] single-port accesses");
        applyStimulus(0, 1'b1, 1'b0, 20'h00000, 32'h0000_5A5A, 1'b0, 32'h0);
        applyStimulus(0, 1'b1, 1'b1, 20'h00010, 32'hCAFE_BABE, 1'b0, 32'h0);
        applyStimulus(0, 1'b0, 1'b1, 20'h00010, 32'h0,         1'b0, 32'hCAFE_BABE);
        applyStimulus(0, 1'b0, 1'b0, 20'h00010, 32'h0,         1'b0, 32'h0000_BABE);
        applyStimulus(1, 1'b0, 1'b0, 20'h00011, 32'h0,         1'b0, 32'h0000_CAFE);
        applyStimulus(1, 1'b1, 1'b0, 20'h003FF, 32'hABCD_1234, 1'b0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 20'h003FF, 32'h0,         1'b0, 32'h0000_1234);
        applyStimulus(0, 1'b0, 1'b1, 20'h003FE, 32'h0,         1'b0, 32'h1234_0000);

        $display("[TB] out-of-range accesses");
        oor_watch = 1'b1;
        applyStimulus(1, 1'b0, 1'b1, 20'h003FF, 32'h0,         1'b1, 32'h0);
        applyStimulus(0, 1'b0, 1'b0, 20'h00400, 32'h0,         1'b1, 32'h0);
        applyStimulus(0, 1'b1, 1'b1, 20'h003FF, 32'h5555_6666, 1'b1, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 20'hFFFFF, 32'h0,         1'b1, 32'h0);
        oor_watch = 1'b0;
        checkOutput("oor_write_blocked", 32'(mem[1023]), 32'h0000_1234);

        $display("[TB] round-robin contention");
        setPort(0, 1'b1, 1'b1, 20'h00100, 32'h0101_0101);
        setPort(1, 1'b1, 1'b0, 20'h00200, 32'h0000_2222);
        q_main.push_back('{port: 1'b0, err: 1'b0, rdata: 32'h0});
        q_main.push_back('{port: 1'b1, err: 1'b0, rdata: 32'h0});
        q_main.push_back('{port: 1'b0, err: 1'b0, rdata: 32'h0});
        q_main.push_back('{port: 1'b1, err: 1'b0, rdata: 32'h0});
        run_pair(0, 2, 2);
        applyStimulus(0, 1'b0, 1'b1, 20'h00100, 32'h0, 1'b0, 32'h0101_0101);
        applyStimulus(1, 1'b0, 1'b0, 20'h00200, 32'h0, 1'b0, 32'h0000_2222);

        $display("[TB] reset during ACCESS");
        setPort(0, 1'b1, 1'b1, 20'h00020, 32'h1111_2222);
        req0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_in_access", 32'(o_mem_write), 32'h1);
        rst = 1'b1;
        #1;
        checkIdleOutputs("abort");
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_write_lost", {mem[33], mem[32]}, 32'h0);
        repeat (3) @(negedge clk);
        setPort(0, 1'b0, 1'b1, 20'h00010, 32'h0);
        setPort(1, 1'b0, 1'b0, 20'h00200, 32'h0);
        q_main.push_back('{port: 1'b0, err: 1'b0, rdata: 32'hCAFE_BABE});
        q_main.push_back('{port: 1'b1, err: 1'b0, rdata: 32'h0000_2222});
        run_pair(0, 1, 1);

        $display("[TB] fixed-priority contention");
        setPort(0, 1'b1, 1'b0, 20'h00005, 32'h0000_0007);
        setPort(1, 1'b1, 1'b0, 20'h00006, 32'h0000_0009);
        for (int i = 0; i < 4; i++) q_fp.push_back('{port: 1'b0, err: 1'b0, rdata: 32'h0});
        q_fp.push_back('{port: 1'b1, err: 1'b0, rdata: 32'h0});
        run_pair(1, 4, 1);

        repeat (3) @(negedge clk);
        checkOutput("main_queue_drained", 32'(q_main.size()), 32'h0);
        checkOutput("fp_queue_drained", 32'(q_fp.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
